// File: rtl/l1_scaler_pkg.sv
// Address map, register bit positions and FSM state types shared by the
// L1 trigger scaler top level and its per-beam slices.
package l1_scaler_pkg;

  localparam logic [11:0] CTRL_OFS    = 12'h000;
  localparam logic [11:0] STATUS_OFS  = 12'h004;
  localparam logic [11:0] PERIOD_OFS  = 12'h008;
  localparam logic [11:0] HOLDOFF_OFS = 12'h00C;
  localparam logic [11:0] COUNT_BASE  = 12'h400;
  localparam logic [11:0] MASK_BASE   = 12'h800;

  // adr[11:10] picks the space, adr[9:2] the word (or beam index) inside it
  localparam logic [1:0] SPACE_REGS  = CTRL_OFS[11:10];
  localparam logic [1:0] SPACE_COUNT = COUNT_BASE[11:10];
  localparam logic [1:0] SPACE_MASK  = MASK_BASE[11:10];

  localparam logic [7:0] WORD_CTRL    = CTRL_OFS[9:2];
  localparam logic [7:0] WORD_STATUS  = STATUS_OFS[9:2];
  localparam logic [7:0] WORD_PERIOD  = PERIOD_OFS[9:2];
  localparam logic [7:0] WORD_HOLDOFF = HOLDOFF_OFS[9:2];

  localparam int CTRL_START = 0;
  localparam int CTRL_MODE  = 1;
  localparam int CTRL_STOP  = 2;

  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_SAT  = 2;
  localparam int ST_MODE = 3;

  typedef enum logic {IDLE, RUN} gate_state_t;
  typedef enum logic {R_IDLE, R_ACK} reg_state_t;

endpackage

// File: rtl/l1_scaler_beam.sv
// One beam slice: holdoff down-counter, mask bit, registered trigger output,
// saturating live counter and the snapshot register software reads.
module l1_scaler_beam #(
  parameter int COUNT_WIDTH   = 32,
  parameter int HOLDOFF_WIDTH = 8
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     trig_i,
  input  logic                     run,
  input  logic                     clear,
  input  logic                     snap,
  input  logic [HOLDOFF_WIDTH-1:0] holdoff_val,
  input  logic                     mask_we,
  input  logic                     mask_d,
  output logic                     trig_o,
  output logic                     mask_o,
  output logic                     sat_o,
  output logic [COUNT_WIDTH-1:0]   count_o
);

  logic [HOLDOFF_WIDTH-1:0] r_holdoff;
  logic [COUNT_WIDTH-1:0]   r_live;
  logic [COUNT_WIDTH-1:0]   r_snap;
  logic [COUNT_WIDTH-1:0]   w_live_next;
  logic                     r_mask;
  logic                     r_trig;
  logic                     w_accept;
  logic                     w_inc;
  logic                     w_at_max;

  assign w_accept = trig_i & ~r_mask & (r_holdoff == '0);
  assign w_inc    = run & w_accept;
  assign w_at_max = &r_live;

  // The snapshot takes the post-increment value, so a trigger accepted in the
  // terminal cycle lands in the period that is closing.
  assign w_live_next = (w_inc && !w_at_max) ? r_live + 1'b1 : r_live;
  assign sat_o       = w_inc & w_at_max;

  // NOTE: state is updated with <= so every flop samples pre-edge values, independent of statement order.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_holdoff <= '0;
      r_live    <= '0;
      // NOTE: the result bank is ordinary per-beam flops, so it is reset with everything else and reads 0 after reset.
      r_snap    <= '0;
      r_mask    <= 1'b0;
      r_trig    <= 1'b0;
    end else begin
      r_trig <= w_accept;
      if (mask_we) r_mask <= mask_d;

      if (w_accept)              r_holdoff <= holdoff_val;
      else if (r_holdoff != '0)  r_holdoff <= r_holdoff - 1'b1;

      if (clear) r_live <= '0;
      else       r_live <= w_live_next;

      if (snap) r_snap <= w_live_next;
    end
  end

  assign trig_o  = r_trig;
  assign mask_o  = r_mask;
  assign count_o = r_snap;

endmodule

// File: rtl/l1_trigger_scaler.sv
// Per-beam L1 trigger rate scaler: gate FSM and period counter, register
// slave with read mux, and one l1_scaler_beam slice per beam.
module l1_trigger_scaler
  import l1_scaler_pkg::*;
#(
  parameter int NBEAMS          = 2,
  parameter int COUNT_WIDTH     = 32,
  parameter int PERIOD_WIDTH    = 32,
  parameter int HOLDOFF_WIDTH   = 8,
  parameter int DEFAULT_PERIOD  = 375000000,
  parameter int DEFAULT_HOLDOFF = 16
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [NBEAMS-1:0] trig_i,
  output logic [NBEAMS-1:0] trig_o,
  output logic              period_done_o,
  input  logic              reg_stb_i,
  input  logic              reg_we_i,
  input  logic [11:0]       reg_adr_i,
  input  logic [31:0]       reg_dat_i,
  output logic              reg_ack_o,
  output logic [31:0]       reg_dat_o
);

  localparam logic [PERIOD_WIDTH-1:0]  PERIOD_RST  = PERIOD_WIDTH'(DEFAULT_PERIOD);
  localparam logic [HOLDOFF_WIDTH-1:0] HOLDOFF_RST = HOLDOFF_WIDTH'(DEFAULT_HOLDOFF);

  gate_state_t r_gate_state, w_gate_next;
  reg_state_t  r_reg_state, w_reg_next;

  logic [PERIOD_WIDTH-1:0]  r_period, r_gate_cnt, r_gate_last;
  logic [HOLDOFF_WIDTH-1:0] r_holdoff, r_holdoff_act, w_holdoff_val;
  logic                     r_mode, r_mode_act, r_done, r_sat_any, r_period_done;
  logic [31:0]              r_rd_data, w_rd_data;

  logic [1:0] w_space;
  logic [7:0] w_word;
  logic       w_req, w_wr, w_busy, w_term;
  logic       w_ctrl_wr, w_period_wr, w_holdoff_wr, w_mask_wr;
  logic       w_start, w_stop, w_load, w_snap, w_clear;
  logic       w_unused_adr;

  logic [NBEAMS-1:0]      w_mask;
  logic [NBEAMS-1:0]      w_sat;
  logic [COUNT_WIDTH-1:0] w_count [NBEAMS];

  // ---------------------------------------------------------------- decode
  assign w_space      = reg_adr_i[11:10];
  assign w_word       = reg_adr_i[9:2];
  assign w_unused_adr = ^reg_adr_i[1:0];

  assign w_req        = (r_reg_state == R_IDLE) & reg_stb_i;
  assign w_wr         = w_req & reg_we_i;
  assign w_ctrl_wr    = w_wr & (w_space == SPACE_REGS) & (w_word == WORD_CTRL);
  assign w_period_wr  = w_wr & (w_space == SPACE_REGS) & (w_word == WORD_PERIOD);
  assign w_holdoff_wr = w_wr & (w_space == SPACE_REGS) & (w_word == WORD_HOLDOFF);
  assign w_mask_wr    = w_wr & (w_space == SPACE_MASK);
  assign w_start      = w_ctrl_wr & reg_dat_i[CTRL_START];
  assign w_stop       = w_ctrl_wr & reg_dat_i[CTRL_STOP];

  assign w_busy = (r_gate_state == RUN);
  assign w_term = w_busy & (r_gate_cnt == r_gate_last);

  // Idle slices see HOLDOFF writes at once; running ones keep the value loaded at (re)start.
  assign w_holdoff_val = w_busy ? r_holdoff_act : r_holdoff;

  // ---------------------------------------------------------------- gate FSM
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    w_gate_next = r_gate_state;
    w_load      = 1'b0;
    w_snap      = 1'b0;
    w_clear     = 1'b0;
    if (w_start) begin
      w_gate_next = RUN;
      w_load      = 1'b1;
      w_clear     = 1'b1;
    end else if (w_term) begin
      w_snap = 1'b1;
      if (w_stop || !r_mode_act) begin
        w_gate_next = IDLE;
      end else begin
        w_load  = 1'b1;
        w_clear = 1'b1;
      end
    end else if (w_stop) begin
      w_gate_next = IDLE;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_gate_state  <= IDLE;
      r_gate_cnt    <= '0;
      r_gate_last   <= '0;
      r_period      <= PERIOD_RST;
      r_holdoff     <= HOLDOFF_RST;
      r_holdoff_act <= HOLDOFF_RST;
      r_mode        <= 1'b0;
      r_mode_act    <= 1'b0;
      r_done        <= 1'b0;
      r_sat_any     <= 1'b0;
      r_period_done <= 1'b0;
    end else begin
      r_gate_state  <= w_gate_next;
      r_period_done <= w_snap;

      // PERIOD = 0 behaves as 1: the terminal count is then 0
      if (w_load) begin
        r_gate_cnt    <= '0;
        r_gate_last   <= (r_period == '0) ? '0 : r_period - 1'b1;
        r_mode_act    <= w_start ? reg_dat_i[CTRL_MODE] : r_mode;
        r_holdoff_act <= r_holdoff;
      end else if (w_busy) begin
        r_gate_cnt <= r_gate_cnt + 1'b1;
      end

      if (w_ctrl_wr)    r_mode    <= reg_dat_i[CTRL_MODE];
      if (w_period_wr)  r_period  <= reg_dat_i[PERIOD_WIDTH-1:0];
      if (w_holdoff_wr) r_holdoff <= reg_dat_i[HOLDOFF_WIDTH-1:0];

      if (w_start)     r_done <= 1'b0;
      else if (w_snap) r_done <= 1'b1;

      if (w_start)     r_sat_any <= 1'b0;
      else if (|w_sat) r_sat_any <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- beams
  for (genvar i = 0; i < NBEAMS; i++) begin : g_beam
    l1_scaler_beam #(
      .COUNT_WIDTH   (COUNT_WIDTH),
      .HOLDOFF_WIDTH (HOLDOFF_WIDTH)
    ) u_beam (
      .aclk        (aclk),
      .aresetn     (aresetn),
      .trig_i      (trig_i[i]),
      .run         (w_busy),
      .clear       (w_clear),
      .snap        (w_snap),
      .holdoff_val (w_holdoff_val),
      .mask_we     (w_mask_wr && (int'(w_word) == i)),
      .mask_d      (reg_dat_i[0]),
      .trig_o      (trig_o[i]),
      .mask_o      (w_mask[i]),
      .sat_o       (w_sat[i]),
      .count_o     (w_count[i])
    );
  end

  // ---------------------------------------------------------------- register slave
  always_comb begin
    w_reg_next = r_reg_state;
    case (r_reg_state)
      R_IDLE:  if (reg_stb_i) w_reg_next = R_ACK;
      R_ACK:   w_reg_next = R_IDLE;
      default: w_reg_next = R_IDLE;
    endcase
  end

  always_comb begin
    w_rd_data = '0;
    case (w_space)
      SPACE_REGS: begin
        case (w_word)
          WORD_STATUS: begin
            w_rd_data[ST_BUSY] = w_busy;
            w_rd_data[ST_DONE] = r_done;
            w_rd_data[ST_SAT]  = r_sat_any;
            w_rd_data[ST_MODE] = r_mode;
          end
          WORD_PERIOD:  w_rd_data = 32'(r_period);
          WORD_HOLDOFF: w_rd_data = 32'(r_holdoff);
          default:      w_rd_data = '0;
        endcase
      end
      SPACE_COUNT: begin
        for (int i = 0; i < NBEAMS; i++)
          if (int'(w_word) == i) w_rd_data = 32'(w_count[i]);
      end
      SPACE_MASK: begin
        for (int i = 0; i < NBEAMS; i++)
          if (int'(w_word) == i) w_rd_data[0] = w_mask[i];
      end
      default: w_rd_data = '0;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_reg_state <= R_IDLE;
      r_rd_data   <= '0;
    end else begin
      r_reg_state <= w_reg_next;
      if (w_req && !reg_we_i) r_rd_data <= w_rd_data;
    end
  end

  assign reg_ack_o     = (r_reg_state == R_ACK);
  assign reg_dat_o     = r_rd_data;
  assign period_done_o = r_period_done;

endmodule

// File: tb/tb_l1_trigger_scaler.sv
// Directed bench for l1_trigger_scaler: register reads go through a scoreboard
// queue popped by an ack monitor; trigger and gate timing is checked inline.
module tb_l1_trigger_scaler;

  localparam int NB = 2;

  localparam logic [11:0] A_CTRL    = 12'h000;
  localparam logic [11:0] A_STATUS  = 12'h004;
  localparam logic [11:0] A_PERIOD  = 12'h008;
  localparam logic [11:0] A_HOLDOFF = 12'h00C;
  localparam logic [11:0] A_COUNT0  = 12'h400;
  localparam logic [11:0] A_COUNT1  = 12'h404;
  localparam logic [11:0] A_COUNT5  = 12'h414;
  localparam logic [11:0] A_MASK0   = 12'h800;
  localparam logic [11:0] A_UNMAP   = 12'h010;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [NB-1:0] trig_i;
  logic [NB-1:0] trig_o;
  logic          period_done_o;
  logic          reg_stb_i;
  logic          reg_we_i;
  logic [11:0]   reg_adr_i;
  logic [31:0]   reg_dat_i;
  logic          reg_ack_o;
  logic [31:0]   reg_dat_o;

  typedef struct {
    string       name;
    logic [31:0] data;
    bit          is_read;
  } sb_t;

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  l1_trigger_scaler #(
    .NBEAMS      (NB),
    .COUNT_WIDTH (8)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .trig_i        (trig_i),
    .trig_o        (trig_o),
    .period_done_o (period_done_o),
    .reg_stb_i     (reg_stb_i),
    .reg_we_i      (reg_we_i),
    .reg_adr_i     (reg_adr_i),
    .reg_dat_i     (reg_dat_i),
    .reg_ack_o     (reg_ack_o),
    .reg_dat_o     (reg_dat_o)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Ack monitor: every ack retires the oldest outstanding request.
  always @(negedge aclk) begin
    if (aresetn && reg_ack_o) begin
      if (sb_q.size() == 0) begin
        check("unexpected_ack", {31'b0, reg_ack_o}, 32'd0);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        if (e.is_read) check(e.name, reg_dat_o, e.data);
      end
    end
  end

  // Waits one edge so the slave is idle, then the request is captured on the following edge.
  task automatic bus(input bit we, input logic [11:0] adr, input logic [31:0] dat,
                     input string name, input logic [31:0] exp);
    sb_t e;
    int  n;
    @(posedge aclk); #1;
    e.name = name; e.data = exp; e.is_read = !we;
    sb_q.push_back(e);
    reg_stb_i = 1'b1; reg_we_i = we; reg_adr_i = adr; reg_dat_i = dat;
    n = 0;
    do begin
      @(posedge aclk); #1;
      n++;
    end while (!reg_ack_o && n < 8);
    if (!reg_ack_o) check({"ack_", name}, {31'b0, reg_ack_o}, 32'd1);
    reg_stb_i = 1'b0; reg_we_i = 1'b0;
  endtask

  task automatic wr(input logic [11:0] adr, input logic [31:0] dat);
    bus(1'b1, adr, dat, "wr", 32'd0);
  endtask

  task automatic rd(input logic [11:0] adr, input logic [31:0] exp, input string name);
    bus(1'b0, adr, 32'd0, name, exp);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] act_v, exp_v;
    logic        seen;
    int          pulses, pulse_at, n;
    int          done_at[$];

    aresetn = 1'b0; trig_i = '0;
    reg_stb_i = 1'b0; reg_we_i = 1'b0; reg_adr_i = '0; reg_dat_i = '0;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_trig_o", 32'(trig_o), 32'd0);
    check("rst_period_done", {31'b0, period_done_o}, 32'd0);
    check("rst_ack", {31'b0, reg_ack_o}, 32'd0);
    check("rst_dat", reg_dat_o, 32'd0);
    aresetn = 1'b1;
    repeat (4) @(posedge aclk);
    #1;
    check("idle_trig_o", 32'(trig_o), 32'd0);
    rd(A_STATUS,  32'd0,         "rst_status");
    rd(A_PERIOD,  32'd375000000, "rst_period");
    rd(A_HOLDOFF, 32'd16,        "rst_holdoff");

    // Holdoff 3, trigger held for cycles 0..9: outputs on cycles 1, 5, 9.
    wr(A_HOLDOFF, 32'd3);
    trig_i[0] = 1'b1;
    act_v = '0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge aclk); #1;
      act_v[c-1] = trig_o[0];
      if (c == 10) trig_i[0] = 1'b0;
    end
    exp_v = 12'h111;
    check("holdoff_pattern", 32'(act_v), 32'(exp_v));

    // One-shot, PERIOD 100: 7 pulses inside the gate (one on the terminal cycle), 2 outside.
    wr(A_PERIOD, 32'd100);
    wr(A_HOLDOFF, 32'd0);
    trig_i[1] = 1'b1;
    @(posedge aclk); #1;
    trig_i[1] = 1'b0;
    wr(A_CTRL, 32'd1);
    pulses = 0; pulse_at = -1;
    for (int k = 0; k < 110; k++) begin
      trig_i[1] = (k inside {3, 10, 20, 40, 60, 80, 99, 105});
      @(posedge aclk); #1;
      if (period_done_o) begin pulses++; pulse_at = k + 1; end
    end
    trig_i[1] = 1'b0;
    check("oneshot_pulses", pulses, 32'd1);
    check("oneshot_done_at", pulse_at, 32'd100);
    rd(A_COUNT1, 32'd7, "oneshot_count1");
    rd(A_COUNT0, 32'd0, "oneshot_count0");
    rd(A_STATUS, 32'h2, "oneshot_status");
    rd(A_COUNT5, 32'd0, "count_beyond_nbeams");
    rd(A_UNMAP,  32'd0, "unmapped_read");

    // Continuous, PERIOD 50, trigger every 10 cycles with one on each terminal cycle.
    wr(A_PERIOD, 32'd50);
    wr(A_CTRL, 32'd3);
    fork
      begin
        for (int k = 0; k < 160; k++) begin
          trig_i[1] = ((k % 10) == 9) && (k < 150);
          @(posedge aclk); #1;
          if (period_done_o) done_at.push_back(k + 1);
        end
        trig_i[1] = 1'b0;
      end
      begin
        repeat (58) @(posedge aclk);
        rd(A_COUNT1, 32'd5, "cont_count_p1");
        repeat (48) @(posedge aclk);
        rd(A_COUNT1, 32'd5, "cont_count_p2");
      end
    join
    check("cont_pulses", done_at.size(), 32'd3);
    for (int i = 0; i < done_at.size() && i < 3; i++)
      check($sformatf("cont_done_%0d", i), done_at[i], 32'(50 * (i + 1)));
    wr(A_CTRL, 32'd4);
    rd(A_COUNT1, 32'd5, "cont_count_p3");
    rd(A_STATUS, 32'h2, "cont_status_after_stop");

    // Saturation on beam 1 (8-bit counters) with beam 0 masked.
    wr(A_MASK0, 32'd1);
    wr(A_PERIOD, 32'd400);
    wr(A_CTRL, 32'd1);
    seen = 1'b0;
    trig_i = 2'b11;
    for (int k = 0; k < 300; k++) begin
      @(posedge aclk); #1;
      seen |= trig_o[0];
    end
    trig_i = '0;
    n = 0;
    while (!period_done_o && n < 200) begin
      @(posedge aclk); #1;
      n++;
    end
    check("sat_period_done", {31'b0, period_done_o}, 32'd1);
    check("mask_trig_o0", {31'b0, seen}, 32'd0);
    rd(A_COUNT1, 32'd255, "sat_count1");
    rd(A_COUNT0, 32'd0,   "mask_count0");
    rd(A_STATUS, 32'h6,   "sat_status");
    wr(A_MASK0, 32'd0);

    // START captured on the terminal edge of a 20-cycle gate.
    wr(A_PERIOD, 32'd20);
    wr(A_CTRL, 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 18; k++) begin
      trig_i[1] = (k == 5);
      @(posedge aclk); #1;
      seen |= period_done_o;
    end
    trig_i[1] = 1'b0;
    wr(A_CTRL, 32'd1);
    check("coll_no_done", {30'b0, seen, period_done_o}, 32'd0);
    pulses = 0; pulse_at = -1;
    for (int k = 0; k < 30; k++) begin
      trig_i[1] = (k == 3);
      @(posedge aclk); #1;
      if (period_done_o) begin pulses++; pulse_at = k + 1; end
    end
    trig_i[1] = 1'b0;
    check("coll_pulses", pulses, 32'd1);
    check("coll_done_at", pulse_at, 32'd20);
    rd(A_COUNT1, 32'd1, "coll_count1");
    rd(A_STATUS, 32'h2, "coll_status");

    // Reset asserted mid-run.
    wr(A_PERIOD, 32'd100);
    wr(A_CTRL, 32'd1);
    trig_i = 2'b10;
    repeat (5) @(posedge aclk);
    #1;
    check("pre_rst_trig_o", 32'(trig_o), 32'd2);
    rd(A_STATUS, 32'h1, "pre_rst_status");
    @(posedge aclk); #1;
    aresetn = 1'b0;
    #2;
    check("mid_rst_trig_o", 32'(trig_o), 32'd0);
    check("mid_rst_period_done", {31'b0, period_done_o}, 32'd0);
    check("mid_rst_ack", {31'b0, reg_ack_o}, 32'd0);
    check("mid_rst_dat", reg_dat_o, 32'd0);
    trig_i = '0;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    rd(A_STATUS,  32'd0,         "post_rst_status");
    rd(A_PERIOD,  32'd375000000, "post_rst_period");
    rd(A_HOLDOFF, 32'd16,        "post_rst_holdoff");
    rd(A_COUNT1,  32'd0,         "post_rst_count1");

    repeat (3) @(posedge aclk);
    #1;
    check("sb_drain", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
